// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-step counter width; kept at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single combinational full-adder cell shared by every bit step of the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit two's-complement adder/subtractor, one bit per clock,
// with a start/done handshake and registered results.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] opa, opb, res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_cout;
    logic             accept, last_step;

    // start is only honoured outside RUN, so operands presented mid-op are dropped.
    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == LAST);

    full_adder_cell u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // On the last step the carry flop still holds the carry into the MSB,
    // so the overflow term is formed directly from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            res   <= {fa_s, res[WIDTH-1:1]};
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            if (last_step) begin
                sum       <= {fa_s, res[WIDTH-1:1]};
                carry_out <= fa_cout;
                overflow  <= carry ^ fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench: directed WIDTH=8 vectors, handshake/abort sequences,
// and an exhaustive WIDTH=4 sweep against a behavioural reference.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, co4, ov4;
    logic [3:0] sum4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
    );

    serial_add_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one WIDTH=8 op and collect it, checking latency and results.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] es, input logic eco, input logic eov,
                        input string name);
        int k;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        check({name, " busy_after_accept"}, {63'd0, busy8}, 64'd1);
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done8) break;
        end
        check({name, " latency"}, 64'(k), 64'd8);
        check({name, " busy_at_done"}, {63'd0, busy8}, 64'd0);
        check({name, " result"}, {54'd0, co8, ov8, sum8}, {54'd0, eco, eov, es});
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        output logic [5:0] got, output int lat);
        int k;
        @(negedge clk);
        a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (done4) break;
        end
        lat = k;
        got = {co4, ov4, sum4};
    endtask

    // Behavioural reference: carry from magnitude compare, overflow from sign rules.
    function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        logic [3:0] s;
        logic       co, ov;
        if (sub) begin
            s  = a - b;
            co = (a >= b);
            ov = (a[3] != b[3]) && (s[3] != a[3]);
        end else begin
            s  = a + b;
            co = ({1'b0, a} + {1'b0, b}) > 5'd15;
            ov = (a[3] == b[3]) && (s[3] != a[3]);
        end
        return {co, ov, s};
    endfunction

    initial begin
        logic [5:0] got4;
        int         lat4;
        logic       saw_done;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        // Reset held for three cycles with random inputs and start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); start8 = 1'b1;
            @(posedge clk);
            #1 check("reset_outputs", {53'd0, busy8, done8, co8, ov8, sum8}, 64'd0);
        end
        @(negedge clk);
        start8 = 1'b0;
        rst_n  = 1'b1;

        foreach (vecs[i])
            run8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_sum,
                 vecs[i].exp_co, vecs[i].exp_ov, $sformatf("vec%0d", i));

        // start pulsed mid-RUN with other operands must be ignored.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                saw_done = 1'b1;
                break;
            end
        end
        check("ignore_start_done", {63'd0, saw_done}, 64'd1);
        check("ignore_start_result", {54'd0, co8, ov8, sum8}, {54'd0, 1'b0, 1'b1, 8'h8D});
        @(posedge clk);
        #1 check("ignore_start_idle", {62'd0, busy8, done8}, 64'd0);

        // start held high across DONE: second op accepted, done every 9 cycles.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 begin a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; end
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                check("b2b_done1", {62'd0, done8, busy8}, 64'd2);
                check("b2b_result1", {54'd0, co8, ov8, sum8}, {54'd0, 1'b1, 1'b0, 8'h00});
            end else if (k == 9) begin
                check("b2b_pulse1_width", {62'd0, done8, busy8}, 64'd1);
                start8 = 1'b0;
            end else if (k == 17) begin
                check("b2b_done2", {62'd0, done8, busy8}, 64'd2);
                check("b2b_result2", {54'd0, co8, ov8, sum8}, {54'd0, 1'b0, 1'b0, 8'hF0});
            end else if (k == 18) begin
                check("b2b_pulse2_width", {62'd0, done8, busy8}, 64'd0);
            end else if (done8) begin
                check("b2b_stray_done", {63'd0, done8}, 64'd0);
            end
        end

        // Asynchronous reset during RUN step 4 aborts the op without a done pulse.
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {53'd0, busy8, done8, co8, ov8, sum8}, 64'd0);
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done8) saw_done = 1'b1;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "after_abort");

        // Exhaustive WIDTH=4 sweep.
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    run4(4'(x), 4'(y), 1'(s), got4, lat4);
                    if (lat4 != 4)
                        check($sformatf("w4_latency a=%0h b=%0h sub=%0d", x, y, s),
                              64'(lat4), 64'd4);
                    check($sformatf("w4 a=%0h b=%0h sub=%0d", x, y, s),
                          {58'd0, got4}, {58'd0, ref4(4'(x), 4'(y), 1'(s))});
                end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised bit-serial adder/subtractor that performs one WIDTH-bit two's-complement add or subtract. It processes one bit per clock through a single full-adder cell, with the carry held in a flip-flop. It is the sequential successor to the team's combinational full-adder blocks and trades latency for area in datapaths where one op per WIDTH+1 cycles is sufficient. A start/done handshake lets a controller launch and collect operations.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  launch request; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b, 1 = a-b; captured with the operands.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse marking a valid result.
- sum  out  WIDTH  result; registered and held until the next result.
- carry_out  out  1  raw carry out of the MSB (for subtract: 1 = no borrow).
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: after WIDTH bit-steps -> DONE.
  - DONE: start=1 -> RUN (back-to-back operation); otherwise -> IDLE.
- Accept (edge 0):
  - opa <= a.
  - opb <= sub ? ~b : b.
  - carry <= sub.
  - bit counter <= 0.
- Each RUN edge:
  - The full-adder cell takes opa[0], opb[0] and carry.
  - Its sum bit shifts into the MSB of the internal result shift register.
  - opa and opb shift right by one.
  - carry <= cout.
  - The counter increments.
  - On the last step (counter = WIDTH-1), cin_msb <= carry (the carry into the MSB) is captured as well.
- Entering DONE:
  - sum <= final shift-register value.
  - carry_out <= cout.
  - overflow <= cin_msb XOR cout.
  - All three hold until the next entry into DONE.
- start is ignored in RUN; operands presented then are discarded.
- Arithmetic is modulo 2^WIDTH. carry_out and overflow are the only out-of-range indications.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Internal registers and counter are all 0.
- Start sampled high at edge 0 (state IDLE or DONE):
  - busy=1 from edge 0 to edge WIDTH.
  - State = DONE after edge WIDTH.
  - done=1 for exactly the cycle between edges WIDTH and WIDTH+1.
  - sum, carry_out and overflow are valid from edge WIDTH.
- Latency from accept to done is WIDTH cycles. Throughput is one op per WIDTH+1 cycles when start is held high.
- done and busy are never high together.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronously). No done pulse is generated for the aborted op.
- Reset deassertion is synchronised externally; the block itself takes no action on it.

## Structure
- Shared package serial_arith_pkg:
  - state typedef with values IDLE, RUN, DONE.
  - Localparam helper for counter width, $clog2(WIDTH).
- Sub-module full_adder_cell: combinational a, b, cin -> s, cout. Instantiated once.
- Top level holds the FSM, operand shift registers, result shift register, carry flop, counter and output registers.

## Test plan
- Reset: assert rst_n=0 for 3 cycles with random inputs -> all outputs 0, busy=0, no done.
- Add, WIDTH=8, sub=0:
  - a=8'h5A, b=8'h33 -> sum=8'h8D, carry_out=0, overflow=1, done exactly 8 edges after accept.
  - a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1, overflow=0.
- Subtract, WIDTH=8, sub=1:
  - a=8'h10, b=8'h20 -> sum=8'hF0, carry_out=0, overflow=0.
  - a=8'h80, b=8'h01 -> sum=8'h7F, carry_out=1, overflow=1.
- Handshake:
  - Pulse start with new operands while busy -> ignored; first result unchanged.
  - Hold start high across DONE -> second op accepted that edge; done pulses every 9 cycles, each pulse one cycle wide.
- Abort: drop rst_n at RUN step 4 -> busy=0 immediately; done stays 0; next op after release gives the correct result.
- WIDTH=4 exhaustive: all a, b, sub combinations checked against a reference model for sum, carry_out and overflow.
